key_debounce: RTL and testbench

//  Per-key synchroniser, debouncer and press classifier for the board push-buttons (key[1:0]).

---
 rtl/key_debounce_pkg.sv | 17 +
 rtl/key_debounce_if.sv | 34 +++
 rtl/key_debounce_ch.sv | 152 +++++++++++++++
 rtl/key_debounce.sv | 47 ++++
 tb/tb_key_debounce.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default timing constants for the key debouncer.
//   key_state_e               : per-channel debounce FSM state (2-bit encoding)
//   DEFAULT_DEBOUNCE_CYCLES   : stable cycles needed to accept a press or release
//   DEFAULT_LONG_PRESS_CYCLES : hold time before a long-press pulse (1 s at 50 MHz)
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 8192;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 50_000_000;

endpackage

// File: rtl/key_debounce_if.sv
// Bundle of key pins and the classified key events.
//   key_in      : raw key pins (driven by the board side / master)
//   key_level   : debounced pressed level, 1 = pressed
//   key_press   : one-cycle pulse on an accepted press
//   key_release : one-cycle pulse on an accepted release
//   key_long    : one-cycle pulse when a press has been held long enough
// Modports: master drives the pins and consumes events; slave is the debouncer.
interface key_debounce_if #(
    parameter int NUM_KEYS = 2
);

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold timer and
// registered event outputs.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   key_raw     : raw key pin, already normalised so that 1 = pressed
//   key_level   : debounced pressed level
//   key_press   : one-cycle pulse on accepted press
//   key_release : one-cycle pulse on accepted release
//   key_long    : one-cycle pulse, at most once per press, after a long hold
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [1:0]        sync_q,       sync_d;
    key_state_e        state_q,      state_d;
    logic [DB_W-1:0]   db_cnt_q,     db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic              long_fired_q, long_fired_d;
    logic              level_q,      level_d;
    logic              press_q,      press_d;
    logic              release_q,    release_d;
    logic              long_q,       long_d;

    logic              k_s;
    logic [HOLD_W-1:0] hold_sat;
    logic              release_accept;

    assign sync_d = {sync_q[0], key_raw};
    assign k_s    = sync_q[1];

    // Hold timer runs for the whole press, including release bounces,
    // and sticks at its last value so it can never wrap.
    assign hold_sat = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q
                                                : hold_cnt_q + HOLD_W'(1);

    assign release_accept = (state_q == RELEASE_WAIT) && !k_s && (db_cnt_q == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_fired_q <= long_fired_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (k_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!k_s)                   state_d = IDLE;
                else if (db_cnt_q == DB_LAST) state_d = PRESSED;
            end
            PRESSED: begin
                if (!k_s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (k_s)                    state_d = PRESSED;
                else if (db_cnt_q == DB_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        db_cnt_d     = db_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        long_fired_d = long_fired_q;
        level_d      = level_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (k_s) db_cnt_d = '0;
            end
            PRESS_WAIT: begin
                if (k_s) begin
                    if (db_cnt_q == DB_LAST) begin
                        press_d      = 1'b1;
                        level_d      = 1'b1;
                        hold_cnt_d   = '0;
                        long_fired_d = 1'b0;
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end
            end
            PRESSED, RELEASE_WAIT: begin
                hold_cnt_d = hold_sat;
                if (state_q == PRESSED) begin
                    if (!k_s) db_cnt_d = '0;
                end else if (!k_s) begin
                    if (release_accept) begin
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end
                // A release accepted on the same cycle takes priority over
                // the long-press pulse so the two never coincide.
                if ((hold_sat == HOLD_LAST) && !long_fired_q && !release_accept) begin
                    long_d       = 1'b1;
                    long_fired_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key front end: polarity normalisation and one debounce channel per key.
//   clk_50m : system clock, 50 MHz
//   rst_n   : asynchronous active-low reset
//   bus     : key pins in, debounced level and press/release/long pulses out
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS          = 2,
    parameter int ACTIVE_HIGH       = 1,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic           clk_50m,
    input  logic           rst_n,
    key_debounce_if.slave  bus
);

    logic [NUM_KEYS-1:0] key_norm;
    logic [NUM_KEYS-1:0] level_w;
    logic [NUM_KEYS-1:0] press_w;
    logic [NUM_KEYS-1:0] release_w;
    logic [NUM_KEYS-1:0] long_w;

    // Channels always see 1 = pressed regardless of the board wiring.
    assign key_norm = (ACTIVE_HIGH != 0) ? bus.key_in : ~bus.key_in;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_ch (
            .clk         (clk_50m),
            .rst_n       (rst_n),
            .key_raw     (key_norm[i]),
            .key_level   (level_w[i]),
            .key_press   (press_w[i]),
            .key_release (release_w[i]),
            .key_long    (long_w[i])
        );
    end

    assign bus.key_level   = level_w;
    assign bus.key_press   = press_w;
    assign bus.key_release = release_w;
    assign bus.key_long    = long_w;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-high and an active-low instance receive
// the same logical key activity (pins inverted for the latter) and are both
// compared every cycle against a run-length / elapsed-time reference model.
module tb_key_debounce;

    localparam int DB = 16;
    localparam int LP = 64;

    logic clk_50m = 1'b0;
    logic rst_n;

    always #10 clk_50m = ~clk_50m;

    key_debounce_if #(.NUM_KEYS(2)) bus_h ();
    key_debounce_if #(.NUM_KEYS(2)) bus_l ();

    key_debounce #(
        .NUM_KEYS(2), .ACTIVE_HIGH(1), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)
    ) dut_h (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus_h)
    );

    key_debounce #(
        .NUM_KEYS(2), .ACTIVE_HIGH(0), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)
    ) dut_l (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus_l)
    );

    int n_checks = 0;
    int n_err    = 0;
    string scen  = "reset";

    // Reference model: pin pipeline, accepted level, length of the current
    // disagreement run, and edges elapsed since the press was accepted.
    logic       s1 [2];
    logic       s2 [2];
    logic       lvl [2];
    int         run [2];
    int         age [2];
    logic [1:0] exp_level, exp_press, exp_release, exp_long;

    // Event log of what the active-high DUT actually produced.
    int step;
    int press_cnt [2], press_step [2];
    int release_cnt [2], release_step [2];
    int long_cnt [2], long_step [2];
    int both_step;

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            s1[k] = 1'b0; s2[k] = 1'b0; lvl[k] = 1'b0; run[k] = 0; age[k] = 0;
        end
        exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
    endtask

    task automatic modelEdge(input logic [1:0] pressed);
        logic ks;
        logic was;
        for (int k = 0; k < 2; k++) begin
            ks    = s2[k];
            s2[k] = s1[k];
            s1[k] = pressed[k];
            exp_press[k] = 1'b0; exp_release[k] = 1'b0; exp_long[k] = 1'b0;
            was = lvl[k];
            // Level flips once the synchronised key has disagreed with it for DB+1 edges.
            if (ks != lvl[k]) run[k]++;
            else              run[k] = 0;
            if (run[k] == DB + 1) begin
                lvl[k] = ks;
                run[k] = 0;
                if (ks) begin exp_press[k] = 1'b1; age[k] = 0; end
                else    exp_release[k] = 1'b1;
            end else if (was && age[k] < LP - 1) begin
                age[k]++;
                if (age[k] == LP - 1) exp_long[k] = 1'b1;
            end
            exp_level[k] = lvl[k];
        end
    endtask

    task automatic clearLog();
        step = 0; both_step = -1;
        for (int k = 0; k < 2; k++) begin
            press_cnt[k] = 0; press_step[k] = -1;
            release_cnt[k] = 0; release_step[k] = -1;
            long_cnt[k] = 0; long_step[k] = -1;
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        n_checks++;
        assert ({bus_h.key_level, bus_h.key_press, bus_h.key_release, bus_h.key_long}
                === {exp_level, exp_press, exp_release, exp_long}) else begin
            n_err++;
            $error("[TB] FAIL %s active_high step %0d: observed=%b expected=%b", scen, step,
                   {bus_h.key_level, bus_h.key_press, bus_h.key_release, bus_h.key_long},
                   {exp_level, exp_press, exp_release, exp_long});
        end
        n_checks++;
        assert ({bus_l.key_level, bus_l.key_press, bus_l.key_release, bus_l.key_long}
                === {exp_level, exp_press, exp_release, exp_long}) else begin
            n_err++;
            $error("[TB] FAIL %s active_low step %0d: observed=%b expected=%b", scen, step,
                   {bus_l.key_level, bus_l.key_press, bus_l.key_release, bus_l.key_long},
                   {exp_level, exp_press, exp_release, exp_long});
        end
    endtask

    // One clock of key activity: drive pins, advance the model on the edge,
    // then sample and compare on the falling edge.
    task automatic applyStimulus(input logic [1:0] pressed);
        bus_h.key_in = pressed;
        bus_l.key_in = ~pressed;
        @(posedge clk_50m);
        modelEdge(pressed);
        @(negedge clk_50m);
        for (int k = 0; k < 2; k++) begin
            if (bus_h.key_press[k])   begin press_cnt[k]++;   press_step[k] = step;   end
            if (bus_h.key_release[k]) begin release_cnt[k]++; release_step[k] = step; end
            if (bus_h.key_long[k])    begin long_cnt[k]++;    long_step[k] = step;    end
        end
        if (bus_h.key_press == 2'b11 && bus_l.key_press == 2'b11) both_step = step;
        checkOutput();
        step++;
    endtask

    task automatic runSteps(input logic [1:0] pressed, input int n);
        for (int i = 0; i < n; i++) applyStimulus(pressed);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_h.key_in = 2'b00;
        bus_l.key_in = 2'b11;
        modelReset();
        clearLog();
        repeat (2) @(negedge clk_50m);
        checkValue("reset_outputs_h", int'({bus_h.key_level, bus_h.key_press, bus_h.key_release, bus_h.key_long}), 0);
        checkValue("reset_outputs_l", int'({bus_l.key_level, bus_l.key_press, bus_l.key_release, bus_l.key_long}), 0);
        rst_n = 1'b1;

        $display("[TB] clean press and release");
        scen = "clean";
        clearLog();
        runSteps(2'b01, 40);
        checkValue("clean_press_step", press_step[0], 18);
        checkValue("clean_press_count", press_cnt[0], 1);
        checkValue("clean_level_held", int'(bus_h.key_level[0]), 1);
        checkValue("clean_no_long", long_cnt[0], 0);
        clearLog();
        runSteps(2'b00, 30);
        checkValue("clean_release_step", release_step[0], 18);

        $display("[TB] press bounce");
        scen = "bounce";
        clearLog();
        for (int t = 0; t < 3; t++) begin
            runSteps(2'b01, 5);
            runSteps(2'b00, 5);
        end
        runSteps(2'b01, 60);
        checkValue("bounce_press_count", press_cnt[0], 1);
        checkValue("bounce_press_step", press_step[0], 48);
        checkValue("bounce_no_release", release_cnt[0], 0);
        runSteps(2'b00, 30);

        $display("[TB] long press");
        scen = "long";
        clearLog();
        runSteps(2'b01, 100);
        checkValue("long_step", long_step[0], 81);
        runSteps(2'b00, 40);
        checkValue("long_release_step", release_step[0], 118);
        checkValue("long_once", long_cnt[0], 1);

        $display("[TB] release bounce");
        scen = "rel_bounce";
        clearLog();
        runSteps(2'b01, 30);
        runSteps(2'b00, 10);
        runSteps(2'b01, 60);
        checkValue("relbounce_no_release", release_cnt[0], 0);
        checkValue("relbounce_level", int'(bus_h.key_level[0]), 1);
        checkValue("relbounce_long_step", long_step[0], 81);
        runSteps(2'b00, 30);

        $display("[TB] simultaneous keys");
        scen = "both";
        clearLog();
        runSteps(2'b11, 25);
        checkValue("both_press_step", both_step, 18);
        runSteps(2'b00, 30);
        checkValue("both_release_count", release_cnt[0] + release_cnt[1], 2);

        $display("[TB] reset mid-press");
        scen = "reset_mid";
        clearLog();
        runSteps(2'b01, 40);
        #3 rst_n = 1'b0;
        #1;
        checkValue("async_reset_h", int'({bus_h.key_level, bus_h.key_press, bus_h.key_release, bus_h.key_long}), 0);
        checkValue("async_reset_l", int'({bus_l.key_level, bus_l.key_press, bus_l.key_release, bus_l.key_long}), 0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        modelReset();
        clearLog();
        runSteps(2'b01, 25);
        checkValue("reset_repress_step", press_step[0], 18);
        runSteps(2'b00, 30);

        $display("[TB] random activity");
        scen = "random";
        for (int seg = 0; seg < 16; seg++) begin
            logic [1:0] p;
            int len;
            p   = 2'($urandom);
            len = int'($urandom_range(1, 90));
            runSteps(p, len);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
